mem_arbiter: RTL and testbench

Parametrised successor to the single-port RAM controller. It arbitrates instruction-cache line reads, data-cache line reads/writes and single-byte IO accesses onto the byte-wide RAM port. Line size and RAM read latency are parameters. Bursts are pipelined at one address per cycle, and icache/dcache get round-robin fairness. Sits between the caches/IO unit and the top-level RAM interface.

---
 rtl/mem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates icache line reads, dcache line reads/writes and IO byte accesses
// onto one byte-wide RAM port with pipelined bursts and icache/dcache round-robin.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_BYTES  = 16,
    parameter int RAM_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic [7:0]              data_from_ram,
    output logic                    rw_select_to_ram,
    output logic [ADDR_WIDTH-1:0]   addr_to_ram,
    output logic [7:0]              data_to_ram,
    input  logic [ADDR_WIDTH-1:0]   addr_from_icache,
    input  logic                    valid_from_icache,
    output logic [8*LINE_BYTES-1:0] data_to_icache,
    output logic                    ready_to_icache,
    input  logic [ADDR_WIDTH-1:0]   addr_from_dcache,
    input  logic [8*LINE_BYTES-1:0] data_from_dcache,
    input  logic                    rw_flag_from_dcache,
    input  logic                    valid_from_dcache,
    output logic [8*LINE_BYTES-1:0] data_to_dcache,
    output logic                    ready_to_dcache,
    input  logic [ADDR_WIDTH-1:0]   addr_from_io,
    input  logic [7:0]              data_from_io,
    input  logic                    rw_flag_from_io,
    input  logic                    valid_from_io,
    output logic [7:0]              data_to_io,
    output logic                    ready_to_io
);
    localparam int OFF = $clog2(LINE_BYTES);
    localparam int LW  = 8 * LINE_BYTES;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [OFF-1:0] LAST_LINE_BEAT = OFF'(LINE_BYTES - 1);
    localparam logic RR_IC = 1'b0;
    localparam logic RR_DC = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;
    typedef enum logic [1:0] {SRC_IC, SRC_DC, SRC_IO} src_e;

    state_e                 state_q, state_d;
    src_e                   src_q, src_d;
    logic                   wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [OFF-1:0]         beat_q, beat_d;
    logic [OFF-1:0]         last_q, last_d;
    logic [OFF-1:0]         cap_q, cap_d;
    logic [RAM_LATENCY-1:0] pipe_q, pipe_d;
    logic                   rr_last_q, rr_last_d;
    logic                   rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [LW-1:0]          ic_data_q, ic_data_d;
    logic [LW-1:0]          dc_data_q, dc_data_d;
    logic [7:0]             io_data_q, io_data_d;
    logic                   ic_rdy_q, ic_rdy_d;
    logic                   dc_rdy_q, dc_rdy_d;
    logic                   io_rdy_q, io_rdy_d;

    logic                   gnt_ic, gnt_dc, gnt_io;
    logic                   push, done;
    src_e                   nsrc;
    logic                   nwr;
    logic [ADDR_WIDTH-1:0]  nbase;

    function automatic logic [7:0] wbyte(input src_e s, input logic [OFF-1:0] k,
                                         input logic [LW-1:0] dl, input logic [7:0] db);
        case (s)
            SRC_DC:  wbyte = dl[{k, 3'b000} +: 8];
            SRC_IO:  wbyte = db;
            default: wbyte = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        wr_d      = wr_q;
        base_d    = base_q;
        beat_d    = beat_q;
        last_d    = last_q;
        cap_d     = cap_q;
        rr_last_d = rr_last_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ic_data_d = ic_data_q;
        dc_data_d = dc_data_q;
        io_data_d = io_data_q;
        ic_rdy_d  = ic_rdy_q;
        dc_rdy_d  = dc_rdy_q;
        io_rdy_d  = io_rdy_q;
        push      = 1'b0;
        done      = 1'b0;

        // IO wins outright; icache/dcache alternate when both are waiting
        gnt_io = valid_from_io;
        gnt_ic = !valid_from_io && valid_from_icache && (!valid_from_dcache || rr_last_q == RR_DC);
        gnt_dc = !valid_from_io && valid_from_dcache && !gnt_ic;
        nsrc   = gnt_io ? SRC_IO : (gnt_ic ? SRC_IC : SRC_DC);
        nwr    = gnt_io ? rw_flag_from_io : (gnt_dc & rw_flag_from_dcache);
        nbase  = gnt_io ? addr_from_io
                        : ((gnt_ic ? addr_from_icache : addr_from_dcache) & ~LINE_MASK);

        case (state_q)
            IDLE: begin
                if (gnt_io || gnt_ic || gnt_dc) begin
                    state_d = ISSUE;
                    src_d   = nsrc;
                    wr_d    = nwr;
                    base_d  = nbase;
                    addr_d  = nbase;
                    rw_d    = nwr;
                    wdata_d = wbyte(nsrc, '0, data_from_dcache, data_from_io);
                    beat_d  = '0;
                    cap_d   = '0;
                    last_d  = gnt_io ? '0 : LAST_LINE_BEAT;
                    push    = !nwr;
                    if (!gnt_io) rr_last_d = gnt_dc ? RR_DC : RR_IC;
                end
            end
            ISSUE: begin
                if (beat_q != last_q) begin
                    beat_d  = beat_q + 1'b1;
                    addr_d  = base_q + ADDR_WIDTH'(beat_d);
                    wdata_d = wbyte(src_q, beat_d, data_from_dcache, data_from_io);
                    push    = !wr_q;
                end else begin
                    rw_d = 1'b0;
                    if (wr_q) done = 1'b1;
                    else      state_d = DRAIN;
                end
            end
            DRAIN: ;
            RESP: begin
                ic_rdy_d = 1'b0;
                dc_rdy_d = 1'b0;
                io_rdy_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Read bytes emerge RAM_LATENCY enabled edges after their address, in order
        pipe_d = RAM_LATENCY'({pipe_q, push});
        if (pipe_q[RAM_LATENCY-1]) begin
            case (src_q)
                SRC_IC:  ic_data_d[{cap_q, 3'b000} +: 8] = data_from_ram;
                SRC_DC:  dc_data_d[{cap_q, 3'b000} +: 8] = data_from_ram;
                default: io_data_d = data_from_ram;
            endcase
            cap_d = cap_q + 1'b1;
            if (cap_q == last_q) done = 1'b1;
        end

        if (done) begin
            state_d = RESP;
            case (src_q)
                SRC_IC:  ic_rdy_d = 1'b1;
                SRC_DC:  dc_rdy_d = 1'b1;
                default: io_rdy_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            src_q     <= SRC_IC;
            wr_q      <= 1'b0;
            base_q    <= '0;
            beat_q    <= '0;
            last_q    <= '0;
            cap_q     <= '0;
            pipe_q    <= '0;
            rr_last_q <= RR_DC;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ic_data_q <= '0;
            dc_data_q <= '0;
            io_data_q <= '0;
            ic_rdy_q  <= 1'b0;
            dc_rdy_q  <= 1'b0;
            io_rdy_q  <= 1'b0;
        end else if (rdy) begin
            state_q   <= state_d;
            src_q     <= src_d;
            wr_q      <= wr_d;
            base_q    <= base_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
            cap_q     <= cap_d;
            pipe_q    <= pipe_d;
            rr_last_q <= rr_last_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ic_data_q <= ic_data_d;
            dc_data_q <= dc_data_d;
            io_data_q <= io_data_d;
            ic_rdy_q  <= ic_rdy_d;
            dc_rdy_q  <= dc_rdy_d;
            io_rdy_q  <= io_rdy_d;
        end
    end

    assign rw_select_to_ram = rw_q;
    assign addr_to_ram      = addr_q;
    assign data_to_ram      = wdata_q;
    assign data_to_icache   = ic_data_q;
    assign data_to_dcache   = dc_data_q;
    assign data_to_io       = io_data_q;
    assign ready_to_icache  = ic_rdy_q;
    assign ready_to_dcache  = dc_rdy_q;
    assign ready_to_io      = io_rdy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RAM latency 2 and 3) share clock, reset and
// rdy, and are checked every cycle against a transaction-level timing/data model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LB = 16;
    localparam int LW = 8 * LB;
    localparam int NI = 2;
    localparam logic [AW-1:0] MASK = AW'(LB - 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]    d_ram  [NI];
    logic          rw_ram [NI];
    logic [AW-1:0] a_ram  [NI];
    logic [7:0]    wd_ram [NI];
    logic [AW-1:0] a_ic   [NI];
    logic          v_ic   [NI];
    logic [LW-1:0] dt_ic  [NI];
    logic          r_ic   [NI];
    logic [AW-1:0] a_dc   [NI];
    logic [LW-1:0] wd_dc  [NI];
    logic          rw_dc  [NI];
    logic          v_dc   [NI];
    logic [LW-1:0] dt_dc  [NI];
    logic          r_dc   [NI];
    logic [AW-1:0] a_io   [NI];
    logic [7:0]    wd_io  [NI];
    logic          rw_io  [NI];
    logic          v_io   [NI];
    logic [7:0]    dt_io  [NI];
    logic          r_io   [NI];
    logic [7:0]    salt = 8'h00;

    function automatic logic [7:0] ram_f(input logic [AW-1:0] a, input logic [7:0] s);
        return a[7:0] ^ s;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [AW-1:0] rp [2];
        // RAM with g+1 register stages: latency g+2, frozen with the global enable
        always @(posedge clk) if (rdy) begin rp[0] <= a_ram[g]; rp[1] <= rp[0]; end
        assign d_ram[g] = ram_f(rp[g], salt);
        mem_arbiter #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .RAM_LATENCY(g + 2)) u_dut (
            .clk(clk), .rst(rst), .rdy(rdy),
            .data_from_ram(d_ram[g]), .rw_select_to_ram(rw_ram[g]),
            .addr_to_ram(a_ram[g]), .data_to_ram(wd_ram[g]),
            .addr_from_icache(a_ic[g]), .valid_from_icache(v_ic[g]),
            .data_to_icache(dt_ic[g]), .ready_to_icache(r_ic[g]),
            .addr_from_dcache(a_dc[g]), .data_from_dcache(wd_dc[g]),
            .rw_flag_from_dcache(rw_dc[g]), .valid_from_dcache(v_dc[g]),
            .data_to_dcache(dt_dc[g]), .ready_to_dcache(r_dc[g]),
            .addr_from_io(a_io[g]), .data_from_io(wd_io[g]),
            .rw_flag_from_io(rw_io[g]), .valid_from_io(v_io[g]),
            .data_to_io(dt_io[g]), .ready_to_io(r_io[g])
        );
    end

    // Transaction model: timing counted in enabled (rdy-high) edges since reset
    int            en;
    bit            busy   [NI];
    int            m_src  [NI];
    logic [AW-1:0] m_base [NI];
    int            m_n    [NI];
    bit            m_wr   [NI];
    int            m_g    [NI];
    int            m_done [NI];
    int            m_free [NI];
    bit            m_rr   [NI];
    logic          e_rw   [NI];
    logic [AW-1:0] e_addr [NI];
    logic [7:0]    e_wd   [NI];
    logic [2:0]    e_rdy  [NI];
    logic [LW-1:0] e_ic   [NI];
    logic [LW-1:0] e_dc   [NI];
    logic [7:0]    e_io   [NI];

    int n_chk = 0;
    int n_err = 0;
    bit gen_on = 1'b0;
    int p_ic, p_dc, p_io, p_wr;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        en = 0;
        for (int d = 0; d < NI; d++) begin
            busy[d] = 0; m_free[d] = 0; m_rr[d] = 1'b1;
            e_rw[d] = 0; e_addr[d] = '0; e_wd[d] = '0; e_rdy[d] = '0;
            e_ic[d] = '0; e_dc[d] = '0; e_io[d] = '0;
        end
    endtask

    task automatic model_edge(input int d, input bit r);
        int k;
        if (r) begin
            if (!busy[d] && en >= m_free[d] && (v_io[d] || v_ic[d] || v_dc[d])) begin
                if (v_io[d])                 m_src[d] = 2;
                else if (v_ic[d] && v_dc[d]) m_src[d] = m_rr[d] ? 0 : 1;
                else                         m_src[d] = v_ic[d] ? 0 : 1;
                if (m_src[d] != 2) m_rr[d] = (m_src[d] == 1);
                case (m_src[d])
                    0: begin m_base[d] = a_ic[d] & ~MASK; m_n[d] = LB; m_wr[d] = 0; end
                    1: begin m_base[d] = a_dc[d] & ~MASK; m_n[d] = LB; m_wr[d] = rw_dc[d]; end
                    default: begin m_base[d] = a_io[d]; m_n[d] = 1; m_wr[d] = rw_io[d]; end
                endcase
                busy[d] = 1; m_g[d] = en;
                m_done[d] = en + (m_wr[d] ? m_n[d] : m_n[d] - 1 + d + 2);
            end
            e_rdy[d] = '0;
            if (busy[d]) begin
                k = en - m_g[d];
                if (k < m_n[d]) begin
                    e_rw[d]   = m_wr[d];
                    e_addr[d] = m_base[d] + AW'(k);
                    e_wd[d]   = (m_src[d] == 1) ? wd_dc[d][8*k +: 8] : wd_io[d];
                end else e_rw[d] = 0;
                if (en == m_done[d]) begin
                    e_rdy[d][m_src[d]] = 1'b1;
                    busy[d] = 0; m_free[d] = en + 2;
                    for (int j = 0; j < m_n[d]; j++) begin
                        if (!m_wr[d] && m_src[d] == 0) e_ic[d][8*j +: 8] = ram_f(m_base[d] + AW'(j), salt);
                        if (!m_wr[d] && m_src[d] == 1) e_dc[d][8*j +: 8] = ram_f(m_base[d] + AW'(j), salt);
                        if (!m_wr[d] && m_src[d] == 2) e_io[d] = ram_f(m_base[d], salt);
                    end
                    case (m_src[d])
                        0: v_ic[d] = 0;
                        1: v_dc[d] = 0;
                        default: v_io[d] = 0;
                    endcase
                end
            end
        end
        chk($sformatf("d%0d_rw", d), LW'(rw_ram[d]), LW'(e_rw[d]));
        chk($sformatf("d%0d_addr", d), LW'(a_ram[d]), LW'(e_addr[d]));
        if (e_rw[d]) chk($sformatf("d%0d_wdata", d), LW'(wd_ram[d]), LW'(e_wd[d]));
        chk($sformatf("d%0d_ready", d), LW'({r_io[d], r_dc[d], r_ic[d]}), LW'(e_rdy[d]));
        if (e_rdy[d] != 0) begin
            chk($sformatf("d%0d_ic_line", d), dt_ic[d], e_ic[d]);
            chk($sformatf("d%0d_dc_line", d), dt_dc[d], e_dc[d]);
            chk($sformatf("d%0d_io_byte", d), LW'(dt_io[d]), LW'(e_io[d]));
        end
    endtask

    task automatic gen(input int d);
        if (!gen_on) return;
        if (!v_ic[d] && !e_rdy[d][0] && $urandom_range(0, 99) < p_ic) begin
            a_ic[d] = $urandom; v_ic[d] = 1;
        end
        if (!v_dc[d] && !e_rdy[d][1] && $urandom_range(0, 99) < p_dc) begin
            a_dc[d] = $urandom; rw_dc[d] = ($urandom_range(0, 99) < p_wr);
            wd_dc[d] = {$urandom, $urandom, $urandom, $urandom}; v_dc[d] = 1;
        end
        if (!v_io[d] && !e_rdy[d][2] && $urandom_range(0, 99) < p_io) begin
            a_io[d] = $urandom; rw_io[d] = ($urandom_range(0, 99) < p_wr);
            wd_io[d] = 8'($urandom); v_io[d] = 1;
        end
    endtask

    task automatic step(input bit r);
        rdy = r;
        @(posedge clk);
        #1;
        if (r) en++;
        for (int d = 0; d < NI; d++) model_edge(d, r);
        for (int d = 0; d < NI; d++) gen(d);
    endtask

    function automatic bit all_idle();
        for (int d = 0; d < NI; d++)
            if (busy[d] || v_ic[d] || v_dc[d] || v_io[d] || e_rdy[d] != 0) return 0;
        return 1;
    endfunction

    task automatic drain(input int max);
        for (int i = 0; i < max && !all_idle(); i++) step(1);
        chk("drain_done", LW'(all_idle()), LW'(1));
    endtask

    task automatic req(input int s, input logic [AW-1:0] a, input bit w, input logic [LW-1:0] wd);
        for (int d = 0; d < NI; d++) begin
            case (s)
                0: begin a_ic[d] = a; v_ic[d] = 1; end
                1: begin a_dc[d] = a; rw_dc[d] = w; wd_dc[d] = wd; v_dc[d] = 1; end
                default: begin a_io[d] = a; rw_io[d] = w; wd_io[d] = wd[7:0]; v_io[d] = 1; end
            endcase
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < NI; d++) begin
            chk({tag, "_rw"}, LW'(rw_ram[d]), '0);
            chk({tag, "_addr"}, LW'(a_ram[d]), '0);
            chk({tag, "_wdata"}, LW'(wd_ram[d]), '0);
            chk({tag, "_lines"}, dt_ic[d] | dt_dc[d] | LW'(dt_io[d]), '0);
            chk({tag, "_readys"}, LW'({r_ic[d], r_dc[d], r_io[d]}), '0);
        end
    endtask

    // Reset asserted between edges; outputs must clear before the next edge
    task automatic async_reset(input string tag);
        rst = 1;
        #1;
        check_zero(tag);
        for (int d = 0; d < NI; d++) begin v_ic[d] = 0; v_dc[d] = 0; v_io[d] = 0; end
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    logic [LW-1:0] wline;

    initial begin
        for (int d = 0; d < NI; d++) begin
            a_ic[d] = '0; v_ic[d] = 0; a_dc[d] = '0; wd_dc[d] = '0; rw_dc[d] = 0; v_dc[d] = 0;
            a_io[d] = '0; wd_io[d] = '0; rw_io[d] = 0; v_io[d] = 0;
        end
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 0;
        model_reset();

        // Icache line read; data = low address byte
        req(0, 32'h0000_1234, 0, '0);
        drain(100);
        chk("ic_line_0x1230", dt_ic[0], 128'h3F3E3D3C3B3A39383736353433323130);

        // Icache and dcache both pending from reset: ic, dc, ic
        async_reset("rst_rr");
        gen_on = 1; p_ic = 100; p_dc = 100; p_io = 0; p_wr = 0;
        repeat (58) step(1);
        gen_on = 0;
        drain(200);

        // Dcache line write
        for (int j = 0; j < LB; j++) wline[8*j +: 8] = 8'hA0 + 8'(j);
        req(1, 32'h0000_0200, 1, wline);
        drain(100);

        // IO read beats a waiting icache; then an IO write
        salt = 8'h5A;
        req(2, 32'h0003_0000, 0, '0);
        req(0, 32'h0000_4000, 0, '0);
        drain(100);
        chk("io_read_byte", LW'(dt_io[1]), LW'(8'h5A));
        req(2, 32'h0003_0001, 1, LW'(8'h77));
        drain(100);
        salt = 8'h00;

        // Icache read stalled for 3 cycles at beat 5
        req(0, 32'h0000_5670, 0, '0);
        repeat (6) step(1);
        repeat (3) step(0);
        drain(100);

        // Reset in the middle of a dcache write burst, then a clean dcache read
        req(1, 32'hFFFF_FFF0, 1, {4{32'hDEADBEEF}});
        repeat (6) step(1);
        async_reset("rst_mid");
        req(1, 32'h0000_0A05, 0, '0);
        drain(100);

        // Randomized traffic with random global stalls
        salt = 8'($urandom);
        gen_on = 1; p_ic = 30; p_dc = 30; p_io = 10; p_wr = 50;
        repeat (3000) step($urandom_range(0, 99) < 85);
        gen_on = 0;
        drain(400);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
